i2c_req_arbiter: RTL and testbench
==================================

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters (2..8).
REQ-002 Parameter POLL_MAX, default 16'hFFFF: maximum consecutive CFG polls before a transfer is aborted.
REQ-003 clk_i  in  1  single clock; all logic on posedge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 req_i  in  N_REQ  per-requester transfer request, level, held until done_o.
REQ-006 req_read_i  in  N_REQ  1 = read transfer, 0 = write transfer.
REQ-007 req_adr_i  in  7*N_REQ  7-bit slave address per requester.
REQ-008 req_nby_i  in  2*N_REQ  byte count per requester (0 = 4 bytes, 1..3 literal).
REQ-009 req_wdata_i  in  32*N_REQ  transmit data per requester, byte 0 first.
REQ-010 done_o  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-011 err_o  out  1  qualifies done_o; 1 = aborted by poll timeout.
REQ-012 rsp_rdata_o  out  32  read data, valid in the done_o cycle.
REQ-013 busy_o  out  1  high from grant until the cycle after done_o.
REQ-014 m_write_o, m_data_be_o[3:0], m_addr_o[4:0], m_wdata_o[31:0]  out; m_rdata_i[31:0]  in  I2C master register port.

Function
REQ-015 Master register map: 0x00 NBY[1:0], 0x04 ADR[6:0], 0x08 RDR, 0x0C TDR, 0x10 CFG[3:0]; write start = CFG 4'b0001, read start = CFG 4'b0100; write done = CFG[1], read done = CFG[3].
REQ-016 States: IDLE, WR_NBY, WR_ADR, WR_TDR, WR_CFG, POLL, RD_RDR, CLR_CFG, DONE; one master access per state cycle.
REQ-017 IDLE: with any req_i high, grant round-robin starting one above the last granted index, wrapping at N_REQ-1; latch read, adr, nby, wdata of the winner; go to WR_NBY next cycle.
REQ-018 Sequence: WR_NBY -> WR_ADR -> WR_TDR (write only, skipped on read) -> WR_CFG -> POLL.
REQ-019 Register writes drive m_write_o=1, m_data_be_o=4'hF, full 32-bit m_wdata_o zero-extended.
REQ-020 POLL: m_write_o=0, m_addr_o=0x10, m_data_be_o=4'h1; on done bit set go to RD_RDR (read) or CLR_CFG (write); else increment poll counter.
REQ-021 RD_RDR: m_addr_o=0x08, m_data_be_o=4'hF; capture m_rdata_i into rsp_rdata_o; go to CLR_CFG.
REQ-022 CLR_CFG: write CFG=0; go to DONE.
REQ-023 DONE: pulse done_o[grant] one cycle with err_o; return to IDLE; next grant no earlier than the following cycle.
REQ-024 Poll counter reaching POLL_MAX: go to CLR_CFG with error flag set; rsp_rdata_o forced to 0.
REQ-025 Outside register-write states m_write_o=0 and m_data_be_o=0 except during POLL/RD_RDR.
REQ-026 Deassertion of req_i mid-transfer is ignored; transfer completes and done_o still pulses.
REQ-027 Requests arriving during a transfer wait; a single requester is re-granted back-to-back.

Reset
REQ-028 On rst_i: state IDLE, RR pointer to N_REQ-1 (first grant to index 0), done_o=0, err_o=0, busy_o=0, rsp_rdata_o=0, all m_* outputs 0, poll counter 0.
REQ-029 Reset mid-transfer abandons it with no done_o; the master resets from the same rst_i.

Configuration
REQ-030 I2C_ARB_TIMEOUT_EN defined: poll counter and REQ-024 present; undefined: counter absent, POLL waits indefinitely, err_o tied 0.

Structure
REQ-031 Package i2c_pkg: register offsets, CFG start/done bit constants, state enumeration.
REQ-032 One sub-module, rr_arbiter: N_REQ request vector, pointer, one-hot grant output.

Verification
REQ-033 Write: req_i[0]=1, adr 0x50, nby 2, wdata 0x0000BEEF; model sets CFG[1] after 10 polls -> writes 2/0x50/0xBEEF/0x1 in order, CFG=0 write, done_o[0] pulse, err_o=0.
REQ-034 Read: req_i[1], read, nby 0; model RDR 0xDEADBEEF, CFG[3] after 5 polls -> no TDR write, rsp_rdata_o=0xDEADBEEF with done_o[1].
REQ-035 Contention: req_i=2'b11 held -> grants alternate 0,1,0,1; four done_o pulses.
REQ-036 Timeout (macro on, POLL_MAX=8): done bit never set -> CFG=0 written after 8 polls, done_o with err_o=1, rsp_rdata_o=0.
REQ-037 Async reset asserted in POLL -> outputs at reset values immediately, no done_o; next request granted to index 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter: master register map, CFG bit
// constants, sequencer states and the per-cycle master access decode.
package i2c_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_NBY = 5'h00;
    localparam logic [ADDR_W-1:0] REG_ADR = 5'h04;
    localparam logic [ADDR_W-1:0] REG_RDR = 5'h08;
    localparam logic [ADDR_W-1:0] REG_TDR = 5'h0C;
    localparam logic [ADDR_W-1:0] REG_CFG = 5'h10;

    localparam logic [3:0]  CFG_WR_START    = 4'b0001;
    localparam logic [3:0]  CFG_RD_START    = 4'b0100;
    localparam int unsigned CFG_WR_DONE_BIT = 1;
    localparam int unsigned CFG_RD_DONE_BIT = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_NBY,
        ST_WR_ADR,
        ST_WR_TDR,
        ST_WR_CFG,
        ST_POLL,
        ST_RD_RDR,
        ST_CLR_CFG,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              write;
        logic [3:0]        be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } m_acc_t;

    // Master port access performed while sitting in state st.
    function automatic m_acc_t m_access(input state_e      st,
                                        input logic        rd,
                                        input logic [6:0]  adr,
                                        input logic [1:0]  nby,
                                        input logic [31:0] wdata);
        m_acc_t acc;
        acc = '0;
        case (st)
            ST_WR_NBY: begin
                acc.write = 1'b1;
                acc.be    = 4'hF;
                acc.addr  = REG_NBY;
                acc.wdata = 32'(nby);
            end
            ST_WR_ADR: begin
                acc.write = 1'b1;
                acc.be    = 4'hF;
                acc.addr  = REG_ADR;
                acc.wdata = 32'(adr);
            end
            ST_WR_TDR: begin
                acc.write = 1'b1;
                acc.be    = 4'hF;
                acc.addr  = REG_TDR;
                acc.wdata = wdata;
            end
            ST_WR_CFG: begin
                acc.write = 1'b1;
                acc.be    = 4'hF;
                acc.addr  = REG_CFG;
                acc.wdata = 32'(rd ? CFG_RD_START : CFG_WR_START);
            end
            ST_POLL: begin
                acc.be    = 4'h1;
                acc.addr  = REG_CFG;
            end
            ST_RD_RDR: begin
                acc.be    = 4'hF;
                acc.addr  = REG_RDR;
            end
            ST_CLR_CFG: begin
                acc.write = 1'b1;
                acc.be    = 4'hF;
                acc.addr  = REG_CFG;
            end
            default: ;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from one above i_ptr, wrapping at N_REQ-1,
// and returns a one-hot grant of the first active request.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt_c,
    output logic             o_valid_c
);

    logic w_found;

    always_comb begin
        o_gnt_c = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!w_found && i_req[IDX_W'((32'(i_ptr) + k) % N_REQ)]) begin
                o_gnt_c[IDX_W'((32'(i_ptr) + k) % N_REQ)] = 1'b1;
                w_found = 1'b1;
            end
        end
        o_valid_c = w_found;
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Arbitrates N_REQ transfer requesters onto one I2C master register port and
// sequences each transfer. Define I2C_ARB_TIMEOUT_EN to enable the poll timeout.
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    req_read_i,
    input  logic [7*N_REQ-1:0]  req_adr_i,
    input  logic [2*N_REQ-1:0]  req_nby_i,
    input  logic [32*N_REQ-1:0] req_wdata_i,
    output logic [N_REQ-1:0]    done_o,
    output logic                err_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                busy_o,
    output logic                m_write_o,
    output logic [3:0]          m_data_be_o,
    output logic [4:0]          m_addr_o,
    output logic [31:0]         m_wdata_o,
    input  logic [31:0]         m_rdata_i
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_e            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic              r_read, w_read_nxt;
    logic [6:0]        r_adr, w_adr_nxt;
    logic [1:0]        r_nby, w_nby_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [31:0]       r_rsp, w_rsp_nxt;
    logic [N_REQ-1:0]  r_done;
    logic              r_busy;
    m_acc_t            r_acc, w_acc;
    logic              w_done_bit;

    logic [N_REQ-1:0]  w_arb_gnt;
    logic              w_arb_valid;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_win_read;
    logic [6:0]        w_win_adr;
    logic [1:0]        w_win_nby;
    logic [31:0]       w_win_wdata;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] POLL_LAST = POLL_MAX - 16'd1;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic        r_err_o;
`else
    logic w_unused_poll_max;
    assign w_unused_poll_max = ^POLL_MAX;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req     (req_i),
        .i_ptr     (r_ptr),
        .o_gnt_c   (w_arb_gnt),
        .o_valid_c (w_arb_valid)
    );

    // Select the winning requester's transfer parameters.
    always_comb begin
        w_win_idx   = '0;
        w_win_read  = 1'b0;
        w_win_adr   = '0;
        w_win_nby   = '0;
        w_win_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_win_idx   = IDX_W'(i);
                w_win_read  = req_read_i[i];
                w_win_adr   = req_adr_i[i*7 +: 7];
                w_win_nby   = req_nby_i[i*2 +: 2];
                w_win_wdata = req_wdata_i[i*32 +: 32];
            end
        end
    end

    // Next-state logic; the master access is decoded for the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_read_nxt  = r_read;
        w_adr_nxt   = r_adr;
        w_nby_nxt   = r_nby;
        w_wdata_nxt = r_wdata;
        w_rsp_nxt   = r_rsp;
`ifdef I2C_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
`endif
        w_done_bit  = r_read ? m_rdata_i[CFG_RD_DONE_BIT] : m_rdata_i[CFG_WR_DONE_BIT];

        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ST_WR_NBY;
                    w_ptr_nxt   = w_win_idx;
                    w_gnt_nxt   = w_arb_gnt;
                    w_read_nxt  = w_win_read;
                    w_adr_nxt   = w_win_adr;
                    w_nby_nxt   = w_win_nby;
                    w_wdata_nxt = w_win_wdata;
`ifdef I2C_ARB_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
`endif
                end
            end
            ST_WR_NBY: w_state_nxt = ST_WR_ADR;
            ST_WR_ADR: w_state_nxt = r_read ? ST_WR_CFG : ST_WR_TDR;
            ST_WR_TDR: w_state_nxt = ST_WR_CFG;
            ST_WR_CFG: begin
                w_state_nxt = ST_POLL;
`ifdef I2C_ARB_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            ST_POLL: begin
                if (w_done_bit) begin
                    w_state_nxt = r_read ? ST_RD_RDR : ST_CLR_CFG;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (r_cnt == POLL_LAST) begin
                    w_state_nxt = ST_CLR_CFG;
                    w_err_nxt   = 1'b1;
                    w_rsp_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                end
`endif
            end
            ST_RD_RDR: begin
                w_rsp_nxt   = m_rdata_i;
                w_state_nxt = ST_CLR_CFG;
            end
            ST_CLR_CFG: w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase

        w_acc = m_access(w_state_nxt, w_read_nxt, w_adr_nxt, w_nby_nxt, w_wdata_nxt);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= IDX_W'(N_REQ - 1);
            r_gnt   <= '0;
            r_read  <= 1'b0;
            r_adr   <= '0;
            r_nby   <= '0;
            r_wdata <= '0;
            r_rsp   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_acc   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_err_o <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_read  <= w_read_nxt;
            r_adr   <= w_adr_nxt;
            r_nby   <= w_nby_nxt;
            r_wdata <= w_wdata_nxt;
            r_rsp   <= w_rsp_nxt;
            r_done  <= (w_state_nxt == ST_DONE) ? r_gnt : '0;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_acc   <= w_acc;
`ifdef I2C_ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_err_o <= (w_state_nxt == ST_DONE) && w_err_nxt;
`endif
        end
    end

    assign done_o      = r_done;
    assign rsp_rdata_o = r_rsp;
    assign busy_o      = r_busy;
    assign m_write_o   = r_acc.write;
    assign m_data_be_o = r_acc.be;
    assign m_addr_o    = r_acc.addr;
    assign m_wdata_o   = r_acc.wdata;
`ifdef I2C_ARB_TIMEOUT_EN
    assign err_o = r_err_o;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter with a behavioural I2C master register
// model; the timeout case runs only when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_req_arbiter;

    localparam int unsigned N = 4;
    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N-1:0]    rd_v;
    logic [7*N-1:0]  adr_v;
    logic [2*N-1:0]  nby_v;
    logic [32*N-1:0] wd_v;
    logic [N-1:0]    done;
    logic            err;
    logic [31:0]     rsp;
    logic            busy;
    logic            m_write;
    logic [3:0]      m_be;
    logic [4:0]      m_addr;
    logic [31:0]     m_wdata;
    logic [31:0]     m_rdata;

    logic        t_read  [N];
    logic [6:0]  t_adr   [N];
    logic [1:0]  t_nby   [N];
    logic [31:0] t_wdata [N];

    always_comb begin
        rd_v  = '0;
        adr_v = '0;
        nby_v = '0;
        wd_v  = '0;
        for (int i = 0; i < N; i++) begin
            rd_v[i]          = t_read[i];
            adr_v[i*7 +: 7]  = t_adr[i];
            nby_v[i*2 +: 2]  = t_nby[i];
            wd_v[i*32 +: 32] = t_wdata[i];
        end
    end

    i2c_req_arbiter #(.N_REQ(N), .POLL_MAX(16'd8)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_read_i(rd_v),
        .req_adr_i(adr_v), .req_nby_i(nby_v), .req_wdata_i(wd_v),
        .done_o(done), .err_o(err), .rsp_rdata_o(rsp), .busy_o(busy),
        .m_write_o(m_write), .m_data_be_o(m_be), .m_addr_o(m_addr),
        .m_wdata_o(m_wdata), .m_rdata_i(m_rdata)
    );

    // Master register model: logs writes, counts CFG polls, raises done after mdl_k polls.
    typedef struct packed {
        logic [3:0]  be;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wlog[$];
    logic [3:0]  mdl_cfg;
    int          mdl_polls;
    int          mdl_k;
    logic [31:0] mdl_rdr;

    assign m_rdata = (m_addr == 5'h10) ? {28'd0, mdl_cfg} :
                     (m_addr == 5'h08) ? mdl_rdr : 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_cfg   <= 4'd0;
            mdl_polls <= 0;
            wlog.delete();
        end else if (m_write) begin
            wlog.push_back({m_be, m_addr, m_wdata});
            if (m_addr == 5'h10) begin
                mdl_cfg <= m_wdata[3:0];
                if (m_wdata[3:0] != 4'd0) mdl_polls <= 0;
            end
        end else if (m_addr == 5'h10 && m_be == 4'h1) begin
            mdl_polls <= mdl_polls + 1;
            if (mdl_polls + 1 >= mdl_k) begin
                if (mdl_cfg[2])      mdl_cfg[3] <= 1'b1;
                else if (mdl_cfg[0]) mdl_cfg[1] <= 1'b1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int mdl_last;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic int exp_grant(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (done != '0) ok = 1'b1;
        end
    endtask

    // Wait for the completion of a transfer granted to idx and check everything it produced.
    task automatic do_xfer(input string nm, input int idx, input logic exp_err,
                           input int exp_polls, output int cyc);
        wr_t e[$];
        bit  ok;
        wait_done(cyc, ok);
        chk({nm, " done seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        chk({nm, " done_o"}, 64'(done), 64'(4'(1) << idx));
        chk({nm, " err_o"}, 64'(err), 64'(exp_err));
        if (exp_err)          chk({nm, " rdata zero"}, 64'(rsp), 64'd0);
        else if (t_read[idx]) chk({nm, " rdata"}, 64'(rsp), 64'(mdl_rdr));
        e.push_back({4'hF, 5'h00, 32'(t_nby[idx])});
        e.push_back({4'hF, 5'h04, 32'(t_adr[idx])});
        if (!t_read[idx]) e.push_back({4'hF, 5'h0C, t_wdata[idx]});
        e.push_back({4'hF, 5'h10, t_read[idx] ? 32'd4 : 32'd1});
        e.push_back({4'hF, 5'h10, 32'd0});
        chk({nm, " write count"}, 64'(wlog.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (i < wlog.size()) chk({nm, " write entry"}, 64'(wlog[i]), 64'(e[i]));
        chk({nm, " polls"}, 64'(mdl_polls), 64'(exp_polls));
        wlog.delete();
        @(negedge clk);
        chk({nm, " done one cycle"}, 64'(done), 64'd0);
        chk({nm, " busy low after"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [N-1:0] req;
        logic        read;
        logic [6:0]  adr;
        logic [1:0]  nby;
        logic [31:0] wdata;
        logic [31:0] rdr;
        int          k;
        int          exp_idx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  cyc;
        int  w;
        bit  found;
        logic [N-1:0] mask;

        vecs[0] = '{"wr idx0",   4'b0001, 1'b0, 7'h50, 2'd2, 32'h0000BEEF, 32'h0,        10, 0};
        vecs[1] = '{"rd idx1",   4'b0010, 1'b1, 7'h21, 2'd0, 32'h0,        32'hDEADBEEF, 5,  1};
        vecs[2] = '{"all req",   4'b1111, 1'b0, 7'h7F, 2'd0, 32'h12345678, 32'h0,        1,  2};
        vecs[3] = '{"wrap mask", 4'b1011, 1'b1, 7'h01, 2'd3, 32'h0,        32'hA5A55A5A, 3,  3};
        vecs[4] = '{"wrap low",  4'b0110, 1'b0, 7'h33, 2'd1, 32'hCAFEF00D, 32'h0,        2,  1};
        vecs[5] = '{"single hi", 4'b1000, 1'b1, 7'h44, 2'd1, 32'h0,        32'h0BADF00D, 1,  3};

        for (int i = 0; i < N; i++) begin
            t_read[i] = 1'b0; t_adr[i] = '0; t_nby[i] = '0; t_wdata[i] = '0;
        end
        req = '0; mdl_k = 1; mdl_rdr = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst done_o", 64'(done), 64'd0);
        chk("rst err_o", 64'(err), 64'd0);
        chk("rst busy_o", 64'(busy), 64'd0);
        chk("rst rdata", 64'(rsp), 64'd0);
        chk("rst m_port", 64'({m_write, m_be, m_addr}), 64'd0);
        chk("rst m_wdata", 64'(m_wdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            t_read[vecs[v].exp_idx]  = vecs[v].read;
            t_adr[vecs[v].exp_idx]   = vecs[v].adr;
            t_nby[vecs[v].exp_idx]   = vecs[v].nby;
            t_wdata[vecs[v].exp_idx] = vecs[v].wdata;
            mdl_k   = vecs[v].k;
            mdl_rdr = vecs[v].rdr;
            req     = vecs[v].req;
            do_xfer(vecs[v].name, vecs[v].exp_idx, 1'b0, vecs[v].k + 1, cyc);
            req = '0;
        end
        mdl_last = 3;

        // Contention on 0 and 1 held: grants alternate 0,1,0,1
        t_read[0] = 1'b0; t_adr[0] = 7'h11; t_nby[0] = 2'd1; t_wdata[0] = 32'h000000AA;
        t_read[1] = 1'b1; t_adr[1] = 7'h22; t_nby[1] = 2'd2;
        mdl_k = 2; mdl_rdr = 32'h13579BDF;
        req = 4'b0011;
        for (int j = 0; j < 4; j++) do_xfer("contention", j % 2, 1'b0, 3, cyc);
        req = '0;
        mdl_last = 1;

        // Single requester re-granted back-to-back: done-to-done spacing
        mdl_k = 3;
        req = 4'b0001;
        do_xfer("b2b first", 0, 1'b0, 4, cyc);
        do_xfer("b2b second", 0, 1'b0, 4, cyc);
        req = '0;
        chk("b2b gap", 64'(cyc), 64'(mdl_k + 7));
        mdl_last = 0;

        // Request dropped mid-transfer still completes
        t_read[2] = 1'b0; t_adr[2] = 7'h5A; t_nby[2] = 2'd3; t_wdata[2] = 32'h00C0FFEE;
        mdl_k = 2;
        req = 4'b0100;
        repeat (2) @(negedge clk);
        chk("drop busy", 64'(busy), 64'd1);
        req = '0;
        do_xfer("drop req", 2, 1'b0, 3, cyc);
        mdl_last = 2;

        // Randomised traffic against the round-robin model
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                t_read[i]  = 1'($urandom);
                t_adr[i]   = 7'($urandom);
                t_nby[i]   = 2'($urandom);
                t_wdata[i] = $urandom;
            end
            mask    = 4'($urandom_range(1, 15));
            mdl_k   = $urandom_range(1, 6);
            mdl_rdr = $urandom;
            req     = mask;
            w       = exp_grant(mask, mdl_last);
            do_xfer("random", w, 1'b0, mdl_k + 1, cyc);
            mdl_last = w;
        end
        req = '0;
        @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
        // Done bit never set: abort after POLL_MAX polls
        t_read[0] = 1'b1; t_adr[0] = 7'h0F; t_nby[0] = 2'd1;
        mdl_k = 100000; mdl_rdr = 32'hFFFFFFFF;
        req = 4'b0001;
        do_xfer("timeout", 0, 1'b1, 8, cyc);
        req = '0;
`else
        // Without timeout, a long poll just waits
        t_read[0] = 1'b0; t_adr[0] = 7'h0F; t_nby[0] = 2'd1; t_wdata[0] = 32'h77;
        mdl_k = 40;
        req = 4'b0001;
        do_xfer("long poll", 0, 1'b0, 41, cyc);
        req = '0;
`endif
        mdl_last = 0;
        @(negedge clk);

        // Async reset while polling abandons the transfer
        t_read[0] = 1'b0; t_adr[0] = 7'h3C; t_nby[0] = 2'd2; t_wdata[0] = 32'h1234;
        mdl_k = 100000;
        req = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (m_addr == 5'h10 && !m_write && busy) found = 1'b1;
        end
        chk("reach poll", 64'(found), 64'd1);
        rst = 1'b1;
        req = '0;
        #1;
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst m_port", 64'({m_write, m_be, m_addr}), 64'd0);
        chk("arst rdata", 64'(rsp), 64'd0);
        @(negedge clk);
        chk("arst no done", 64'(done), 64'd0);
        rst = 1'b0;
        t_read[1] = 1'b1;
        mdl_k = 2; mdl_rdr = 32'h600DCAFE;
        req = 4'b0011;
        do_xfer("after reset", 0, 1'b0, 3, cyc);
        req = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
